// File: rtl/sprite_rom_arbiter_if.sv
// sprite_rom_arbiter_if: requester-side and ROM-side bus of the sprite ROM arbiter
interface sprite_rom_arbiter_if #(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 16
);
  logic              arb_en;
  logic [3:0]        req;
  logic [4*ADDR_W-1:0] addr;
  logic [3:0]        gnt;
  logic              rom_rd_en;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;
  logic [3:0]        rd_valid;
  logic [DATA_W-1:0] rd_data;
  logic              busy;
  modport slave (
    input  arb_en, req, addr, rom_data,
    output gnt, rom_rd_en, rom_addr, rd_valid, rd_data, busy
  );
  modport master (
    output arb_en, req, addr, rom_data,
    input  gnt, rom_rd_en, rom_addr, rd_valid, rd_data, busy
  );
endinterface

// File: rtl/sprite_rom_arbiter.sv
// sprite_rom_arbiter: 4-way round-robin arbiter for a fixed-latency sprite ROM with in-order tagged returns
module sprite_rom_arbiter #(
  parameter int ADDR_W  = 20,
  parameter int DATA_W  = 16,
  parameter int ROM_LAT = 2
) (
  input logic                  vga_clk,
  input logic                  sys_rst,
  sprite_rom_arbiter_if.slave  bus
);
  logic [1:0]              ptr_q, ptr_d, win;
  logic                    found;
  logic [ROM_LAT:0][2:0]   tag_q, tag_d;
  logic                    rom_rd_en_q, rom_rd_en_d;
  logic [ADDR_W-1:0]       rom_addr_q, rom_addr_d;
  logic [3:0]              rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]       rd_data_q, rd_data_d;
  logic                    any_tag;
  always_comb begin
    found = 1'b0;
    win = ptr_q;
    for (int i = 0; i < 4; i++)
      if (!found && bus.req[ptr_q + 2'(i)]) begin
        found = 1'b1;
        win = ptr_q + 2'(i);
      end
    found = found && bus.arb_en && !sys_rst;
  end
  // tag stage k travels with the read k+1 cycles after its grant; the last stage meets rom_data
  always_comb begin
    ptr_d = found ? win + 2'd1 : ptr_q;
    rom_rd_en_d = found;
    rom_addr_d = found ? bus.addr[win*ADDR_W +: ADDR_W] : rom_addr_q;
    tag_d = {tag_q[ROM_LAT-1:0], {found, win}};
    rd_valid_d = tag_q[ROM_LAT][2] ? 4'b1 << tag_q[ROM_LAT][1:0] : 4'b0;
    rd_data_d = tag_q[ROM_LAT][2] ? bus.rom_data : rd_data_q;
    any_tag = 1'b0;
    for (int i = 0; i <= ROM_LAT; i++) any_tag = any_tag | tag_q[i][2];
  end
  always_ff @(posedge vga_clk or posedge sys_rst) begin
    if (sys_rst) begin
      ptr_q <= '0;
      tag_q <= '0;
      rom_rd_en_q <= 1'b0;
      rom_addr_q <= '0;
      rd_valid_q <= '0;
      rd_data_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      tag_q <= tag_d;
      rom_rd_en_q <= rom_rd_en_d;
      rom_addr_q <= rom_addr_d;
      rd_valid_q <= rd_valid_d;
      rd_data_q <= rd_data_d;
    end
  end
  assign bus.gnt = found ? 4'b1 << win : 4'b0;
  assign bus.rom_rd_en = rom_rd_en_q;
  assign bus.rom_addr = rom_addr_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.rd_data = rd_data_q;
  assign bus.busy = any_tag | (|rd_valid_q);
endmodule

// File: tb/tb_sprite_rom_arbiter.sv
// tb_sprite_rom_arbiter: directed and random checks of grants and tagged returns against a scoreboard
module tb_sprite_rom_arbiter;
  localparam int ADDR_W = 20, DATA_W = 16, ROM_LAT = 2, LAT = ROM_LAT + 2;
  typedef struct {logic [3:0] id; logic [DATA_W-1:0] data; int cyc;} ret_t;
  logic clk = 1'b0, rst = 1'b1;
  int cyc = 0, n_chk = 0, n_fail = 0, pulses = 0, last_rv = -1, p0, fall;
  ret_t sb[$];
  logic [1:0] mptr = 2'd0;
  logic [3:0] g_last = 4'b0, pend;
  logic [DATA_W-1:0] rom_pipe [ROM_LAT];
  sprite_rom_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus();
  sprite_rom_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ROM_LAT(ROM_LAT)) dut (
    .vga_clk(clk), .sys_rst(rst), .bus(bus)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic logic [DATA_W-1:0] rom_f(input logic [ADDR_W-1:0] a);
    return DATA_W'(a ^ (a >> 5)) ^ 16'h5A3C;
  endfunction
  function automatic logic [3:0] rr(input logic [1:0] p, input logic [3:0] r);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] j;
      j = p + 2'(i);
      if (r[j]) return 4'b1 << j;
    end
    return 4'b0;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // ROM model: registered read, data valid ROM_LAT cycles after the address
  always @(posedge clk) begin
    rom_pipe[0] <= rom_f(bus.rom_addr);
    for (int k = 1; k < ROM_LAT; k++) rom_pipe[k] <= rom_pipe[k-1];
  end
  assign bus.rom_data = rom_pipe[ROM_LAT-1];
  always @(negedge clk) begin
    logic [3:0] eg;
    ret_t e;
    if (rst) begin
      sb.delete();
      mptr = 2'd0;
    end
    eg = (rst || !bus.arb_en) ? 4'b0 : rr(mptr, bus.req);
    chk("gnt", bus.gnt, eg);
    chk("gnt_onehot", 32'($countones(bus.gnt) <= 1), 1);
    chk("busy", bus.busy, 32'(bus.rd_valid != 4'b0 || sb.size() != 0));
    if (bus.rd_valid != 4'b0) begin
      pulses++;
      last_rv = cyc;
      if (sb.size() == 0) chk("spurious_rd_valid", bus.rd_valid, 0);
      else begin
        e = sb.pop_front();
        chk("rd_valid", bus.rd_valid, e.id);
        chk("rd_data", bus.rd_data, e.data);
        chk("ret_cycle", cyc, e.cyc);
      end
    end
    for (int i = 0; i < 4; i++)
      if (eg[i]) begin
        sb.push_back('{eg, rom_f(bus.addr[i*ADDR_W +: ADDR_W]), cyc + LAT});
        mptr = 2'(i + 1);
      end
    g_last = bus.gnt;
  end
  initial begin
    bus.arb_en = 1'b1;
    bus.req = 4'b1111;
    bus.addr = '0;
    for (int i = 0; i < 4; i++) bus.addr[i*ADDR_W +: ADDR_W] = ADDR_W'(32'h10 * (i + 1));
    repeat (2) @(negedge clk);
    chk("rst_gnt", bus.gnt, 0);
    chk("rst_rom_rd_en", bus.rom_rd_en, 0);
    chk("rst_rom_addr", bus.rom_addr, 0);
    chk("rst_rd_valid", bus.rd_valid, 0);
    chk("rst_rd_data", bus.rd_data, 0);
    chk("rst_busy", bus.busy, 0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rr_seq", bus.gnt, 32'(4'b1 << (i % 4)));
    end
    step();
    bus.req = 4'b0;
    repeat (LAT + 2) step();
    bus.addr[2*ADDR_W +: ADDR_W] = 20'h00123;
    bus.req = 4'b0100;
    @(negedge clk);
    chk("single_gnt", bus.gnt, 4'b0100);
    step();
    bus.req = 4'b0;
    @(negedge clk);
    chk("single_rd_en", bus.rom_rd_en, 1);
    chk("single_rom_addr", bus.rom_addr, 20'h00123);
    repeat (ROM_LAT + 1) @(negedge clk);
    chk("single_rd_valid", bus.rd_valid, 4'b0100);
    chk("single_rd_data", bus.rd_data, rom_f(20'h00123));
    step();
    bus.req = 4'b0010;
    @(negedge clk);
    chk("to1_gnt", bus.gnt, 4'b0010);
    step();
    bus.req = 4'b0011;
    @(negedge clk);
    chk("ptr2_gnt0", bus.gnt, 4'b0001);
    step();
    @(negedge clk);
    chk("ptr2_gnt1", bus.gnt, 4'b0010);
    step();
    bus.req = 4'b0;
    repeat (LAT + 2) step();
    bus.req = 4'b1111;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    bus.arb_en = 1'b0;
    p0 = pulses;
    fall = -1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (!bus.busy && fall < 0) fall = cyc;
    end
    chk("en_drop_pulses", pulses - p0, 2);
    chk("busy_fall", fall - last_rv, 1);
    step();
    bus.req = 4'b0;
    bus.arb_en = 1'b1;
    repeat (2) step();
    bus.req = 4'b1111;
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    @(negedge clk);
    step();
    rst = 1'b1;
    bus.req = 4'b0110;
    @(negedge clk);
    chk("midrst_gnt", bus.gnt, 0);
    chk("midrst_rom_rd_en", bus.rom_rd_en, 0);
    chk("midrst_rom_addr", bus.rom_addr, 0);
    chk("midrst_rd_valid", bus.rd_valid, 0);
    chk("midrst_rd_data", bus.rd_data, 0);
    chk("midrst_busy", bus.busy, 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("postrst_gnt", bus.gnt, 4'b0010);
    step();
    bus.req = 4'b0;
    repeat (LAT + 4) step();
    for (int n = 0; n < 3000; n++) begin
      step();
      pend = bus.req & ~g_last;
      for (int i = 0; i < 4; i++)
        if (!pend[i]) bus.addr[i*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
      bus.req = pend | 4'($urandom_range(0, 15) & $urandom_range(0, 15));
      bus.arb_en = ($urandom_range(0, 9) != 0);
    end
    step();
    bus.req = 4'b0;
    repeat (LAT + 4) step();
    chk("final_drain", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
